id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register feeding the ALU. Captures decoded fields, resolves operands with
//  EX/MEM and MEM/WB forwarding, applies operand-select muxing, and drives alu_a/alu_b/alu_op

---
 rtl/id_ex_operand_stage.sv | 176 +++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register in front of the ALU: resolves forwarded operands, applies the
// operand-select muxes, registers the ALU inputs and inserts one bubble on a load-use hazard.
module id_ex_operand_stage #(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [4:0]       in_alu_op,
   input  logic [4:0]       in_rs,
   input  logic [4:0]       in_rt,
   input  logic [4:0]       in_rd,
   input  logic [DW-1:0]    in_rs_val,
   input  logic [DW-1:0]    in_rt_val,
   input  logic [DW-1:0]    in_imm,
   input  logic [1:0]       in_a_sel,
   input  logic [1:0]       in_b_sel,
   input  logic             in_uses_rt,
   input  logic             in_reg_write,
   input  logic             in_is_load,
   input  logic             exm_wen,
   input  logic [4:0]       exm_rd,
   input  logic [DW-1:0]    exm_val,
   input  logic             mwb_wen,
   input  logic [4:0]       mwb_rd,
   input  logic [DW-1:0]    mwb_val,
   output logic [DW-1:0]    alu_a,
   output logic [DW-1:0]    alu_b,
   output logic [4:0]       alu_op,
   output logic             out_valid,
   output logic [4:0]       out_rd,
   output logic             out_reg_write,
   output logic             out_is_load,
   output logic             hazard,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef struct packed {
      logic          valid;
      logic [4:0]    op;
      logic [4:0]    rd;
      logic          reg_write;
      logic          is_load;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } stage_t;

   typedef enum logic [2:0] {
      ACT_FLUSH,
      ACT_HOLD,
      ACT_HAZARD,
      ACT_CAPTURE,
      ACT_BUBBLE
   } action_t;

   stage_t           stage_q, stage_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    fwd_rs, fwd_rt;
   logic [DW-1:0]    a_mux, b_mux;
   logic [DW-1:0]    shamt;
   action_t          act;

   // Register 0 is hard-wired zero, so it is never forwarded; EX/MEM is younger than MEM/WB.
   function automatic logic [DW-1:0] resolve(
      input logic [4:0]    src,
      input logic [DW-1:0] rf_val,
      input logic          e_wen,
      input logic [4:0]    e_rd,
      input logic [DW-1:0] e_val,
      input logic          m_wen,
      input logic [4:0]    m_rd,
      input logic [DW-1:0] m_val
   );
      if (src == 5'd0)
         return '0;
      else if (e_wen && e_rd == src)
         return e_val;
      else if (m_wen && m_rd == src)
         return m_val;
      else
         return rf_val;
   endfunction

   assign fwd_rs = resolve(in_rs, in_rs_val, exm_wen, exm_rd, exm_val, mwb_wen, mwb_rd, mwb_val);
   assign fwd_rt = resolve(in_rt, in_rt_val, exm_wen, exm_rd, exm_val, mwb_wen, mwb_rd, mwb_val);
   assign shamt  = {{(DW-5){1'b0}}, in_imm[10:6]};

   always_comb begin
      a_mux = '0;
      case (in_a_sel)
         2'd0, 2'd3: a_mux = fwd_rs;
         2'd1:       a_mux = fwd_rt;
         default:    a_mux = '0;
      endcase
   end

   always_comb begin
      b_mux = '0;
      case (in_b_sel)
         2'd0, 2'd3: b_mux = fwd_rt;
         2'd1:       b_mux = in_imm;
         default:    b_mux = shamt;
      endcase
   end

   // Load-use check against the instruction now in EX; deliberately blind to stall.
   assign hazard = stage_q.valid && stage_q.is_load && (stage_q.rd != 5'd0) && in_valid &&
                   ((stage_q.rd == in_rs) || (in_uses_rt && (stage_q.rd == in_rt)));

   always_comb begin
      act = ACT_BUBBLE;
      if (flush)
         act = ACT_FLUSH;
      else if (stall)
         act = ACT_HOLD;
      else if (hazard)
         act = ACT_HAZARD;
      else if (in_valid)
         act = ACT_CAPTURE;
      else
         act = ACT_BUBBLE;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      stage_d = stage_q;
      cnt_d   = cnt_q;
      case (act)
         ACT_HOLD: stage_d = stage_q;
         ACT_HAZARD: begin
            stage_d = '0;
            if (cnt_q != '1)
               cnt_d = cnt_q + CNT_W'(1);
         end
         ACT_CAPTURE: begin
            stage_d.valid     = 1'b1;
            stage_d.op        = in_alu_op;
            stage_d.rd        = in_rd;
            stage_d.reg_write = in_reg_write;
            stage_d.is_load   = in_is_load;
            stage_d.a         = a_mux;
            stage_d.b         = b_mux;
         end
         default: stage_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         stage_q <= '0;
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
      end
   end

   assign alu_a         = stage_q.a;
   assign alu_b         = stage_q.b;
   assign alu_op        = stage_q.op;
   assign out_valid     = stage_q.valid;
   assign out_rd        = stage_q.rd;
   assign out_reg_write = stage_q.reg_write;
   assign out_is_load   = stage_q.is_load;
   assign bubble_cnt    = cnt_q;

   // An empty stage must present a fully neutral instruction to EX.
   bubble_is_clean: assert property (@(posedge clk) disable iff (!rst_n)
      !out_valid |-> (alu_op == 5'd0 && !out_reg_write && !out_is_load &&
                      out_rd == 5'd0 && alu_a == '0 && alu_b == '0));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding, operand muxing, load-use bubbles,
// stall/flush priority, reset and counter saturation (on a narrow-counter second instance).
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall, flush, in_valid;
   logic [4:0]  in_alu_op, in_rs, in_rt, in_rd;
   logic [31:0] in_rs_val, in_rt_val, in_imm;
   logic [1:0]  in_a_sel, in_b_sel;
   logic        in_uses_rt, in_reg_write, in_is_load;
   logic        exm_wen, mwb_wen;
   logic [4:0]  exm_rd, mwb_rd;
   logic [31:0] exm_val, mwb_val;

   logic [31:0] alu_a, alu_b;
   logic [4:0]  alu_op, out_rd;
   logic        out_valid, out_reg_write, out_is_load, hazard;
   logic [15:0] bubble_cnt;

   logic [31:0] s_alu_a, s_alu_b;
   logic [4:0]  s_alu_op, s_out_rd;
   logic        s_out_valid, s_out_reg_write, s_out_is_load, s_hazard;
   logic [3:0]  s_bubble_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_alu_op(in_alu_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_uses_rt(in_uses_rt),
      .in_reg_write(in_reg_write), .in_is_load(in_is_load),
      .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_val(exm_val),
      .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_valid(out_valid),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .out_is_load(out_is_load),
      .hazard(hazard), .bubble_cnt(bubble_cnt)
   );

   id_ex_operand_stage #(.DW(32), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_alu_op(in_alu_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_uses_rt(in_uses_rt),
      .in_reg_write(in_reg_write), .in_is_load(in_is_load),
      .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_val(exm_val),
      .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
      .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op), .out_valid(s_out_valid),
      .out_rd(s_out_rd), .out_reg_write(s_out_reg_write), .out_is_load(s_out_is_load),
      .hazard(s_hazard), .bubble_cnt(s_bubble_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; flush = 0; in_valid = 0; in_alu_op = 0;
      in_rs = 0; in_rt = 0; in_rd = 0; in_rs_val = 0; in_rt_val = 0; in_imm = 0;
      in_a_sel = 0; in_b_sel = 0; in_uses_rt = 0; in_reg_write = 0; in_is_load = 0;
      exm_wen = 0; exm_rd = 0; exm_val = 0; mwb_wen = 0; mwb_rd = 0; mwb_val = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b want 0", out_valid); end
      rst_n = 1;
      tick();
      checks++; if (alu_op !== 5'd0) begin errors++; $display("FAIL reset_alu_op: got %h want 0", alu_op); end
      checks++; if (alu_a !== 32'd0) begin errors++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
      checks++; if (alu_b !== 32'd0) begin errors++; $display("FAIL reset_alu_b: got %h want 0", alu_b); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0", bubble_cnt); end
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", hazard); end
   endtask

   task automatic test_forwarding();
      clear_inputs();
      in_valid = 1; in_alu_op = 5'd1; in_rs = 5'd3; in_rs_val = 32'd5; in_rt = 5'd6; in_rt_val = 32'd2;
      in_rd = 5'd8; in_reg_write = 1;
      exm_wen = 1; exm_rd = 5'd3; exm_val = 32'd9;
      mwb_wen = 1; mwb_rd = 5'd3; mwb_val = 32'd7;
      tick();
      checks++; if (alu_a !== 32'd9) begin errors++; $display("FAIL fwd_exm_wins: got %h want 9", alu_a); end
      checks++; if (alu_b !== 32'd2) begin errors++; $display("FAIL fwd_rt_plain: got %h want 2", alu_b); end
      checks++; if (alu_op !== 5'd1) begin errors++; $display("FAIL fwd_op: got %h want 1", alu_op); end
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd8 || out_reg_write !== 1'b1 || out_is_load !== 1'b0)
         begin errors++; $display("FAIL fwd_ctrl: valid=%b rd=%0d rw=%b ld=%b want 1/8/1/0", out_valid, out_rd, out_reg_write, out_is_load); end
      exm_wen = 0;
      tick();
      checks++; if (alu_a !== 32'd7) begin errors++; $display("FAIL fwd_mwb: got %h want 7", alu_a); end
      mwb_wen = 0;
      tick();
      checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL fwd_none: got %h want 5", alu_a); end
      exm_wen = 1; exm_rd = 5'd4; exm_val = 32'hBAD;
      mwb_wen = 1; mwb_rd = 5'd6; mwb_val = 32'h55;
      tick();
      checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL fwd_rd_mismatch: got %h want 5", alu_a); end
      checks++; if (alu_b !== 32'h55) begin errors++; $display("FAIL fwd_rt_mwb: got %h want 55", alu_b); end
      exm_rd = 5'd6;
      tick();
      checks++; if (alu_b !== 32'hBAD) begin errors++; $display("FAIL fwd_rt_exm: got %h want bad", alu_b); end
   endtask

   task automatic test_load_use();
      clear_inputs();
      in_valid = 1; in_alu_op = 5'd1; in_is_load = 1; in_reg_write = 1; in_rd = 5'd4;
      in_rs = 5'd1; in_rs_val = 32'h100; in_imm = 32'd8; in_b_sel = 2'd1;
      tick();
      checks++; if (out_is_load !== 1'b1 || out_rd !== 5'd4 || alu_a !== 32'h100 || alu_b !== 32'd8)
         begin errors++; $display("FAIL load_capture: ld=%b rd=%0d a=%h b=%h want 1/4/100/8", out_is_load, out_rd, alu_a, alu_b); end
      in_is_load = 0; in_rd = 5'd5; in_rs = 5'd4; in_rs_val = 32'hDEAD;
      in_rt = 5'd2; in_rt_val = 32'd3; in_uses_rt = 1; in_b_sel = 2'd0;
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hazard_rs: got %b want 1", hazard); end
      tick();
      checks++; if (alu_op !== 5'd0 || out_valid !== 1'b0 || out_reg_write !== 1'b0 || alu_a !== 32'd0)
         begin errors++; $display("FAIL hazard_bubble: op=%h valid=%b rw=%b a=%h want 0/0/0/0", alu_op, out_valid, out_reg_write, alu_a); end
      checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL hazard_cnt1: got %0d want 1", bubble_cnt); end
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_clears: got %b want 0", hazard); end
      mwb_wen = 1; mwb_rd = 5'd4; mwb_val = 32'h1234;
      tick();
      checks++; if (alu_a !== 32'h1234 || alu_b !== 32'd3) begin errors++; $display("FAIL recapture: a=%h b=%h want 1234/3", alu_a, alu_b); end
      checks++; if (alu_op !== 5'd1 || out_valid !== 1'b1 || out_rd !== 5'd5 || bubble_cnt !== 16'd1)
         begin errors++; $display("FAIL recapture_ctrl: op=%h valid=%b rd=%0d cnt=%0d want 1/1/5/1", alu_op, out_valid, out_rd, bubble_cnt); end
      clear_inputs();
      in_valid = 1; in_alu_op = 5'd1; in_is_load = 1; in_reg_write = 1; in_rd = 5'd7; in_rs = 5'd1;
      tick();
      in_is_load = 0; in_rd = 5'd9; in_rs = 5'd1; in_rt = 5'd7; in_uses_rt = 0;
      #1;
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_rt_unused: got %b want 0", hazard); end
      in_uses_rt = 1;
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hazard_rt_used: got %b want 1", hazard); end
      tick();
      checks++; if (bubble_cnt !== 16'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL hazard_cnt2: cnt=%0d valid=%b want 2/0", bubble_cnt, out_valid); end
      in_is_load = 1; in_rd = 5'd0; in_rs = 5'd2; in_rt = 5'd0;
      tick();
      in_is_load = 0; in_rd = 5'd9; in_rs = 5'd0; in_rt = 5'd0;
      #1;
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_r0: got %b want 0", hazard); end
      tick();
      checks++; if (out_valid !== 1'b1 || bubble_cnt !== 16'd2) begin errors++; $display("FAIL r0_no_bubble: valid=%b cnt=%0d want 1/2", out_valid, bubble_cnt); end
   endtask

   task automatic test_operand_select();
      clear_inputs();
      in_valid = 1; in_alu_op = 5'hD; in_a_sel = 2'd1; in_b_sel = 2'd2;
      in_rs = 5'd10; in_rs_val = 32'hAAAA; in_rt = 5'd9; in_rt_val = 32'd1; in_imm = 32'hABCD_F97F;
      tick();
      checks++; if (alu_a !== 32'd1 || alu_b !== 32'd5 || alu_op !== 5'hD)
         begin errors++; $display("FAIL sll: a=%h b=%h op=%h want 1/5/d", alu_a, alu_b, alu_op); end
      in_alu_op = 5'h10; in_a_sel = 2'd2; in_b_sel = 2'd1;
      tick();
      checks++; if (alu_a !== 32'd0 || alu_b !== 32'hABCD_F97F || alu_op !== 5'h10)
         begin errors++; $display("FAIL sel_zero_imm: a=%h b=%h op=%h want 0/abcdf97f/10", alu_a, alu_b, alu_op); end
      in_a_sel = 2'd3; in_b_sel = 2'd3;
      tick();
      checks++; if (alu_a !== 32'hAAAA || alu_b !== 32'd1) begin errors++; $display("FAIL sel_3: a=%h b=%h want aaaa/1", alu_a, alu_b); end
   endtask

   task automatic test_stall_flush();
      clear_inputs();
      in_valid = 1; in_alu_op = 5'd2; in_is_load = 1; in_reg_write = 1; in_rd = 5'd3;
      in_rs = 5'd1; in_rs_val = 32'h11; in_rt = 5'd2; in_rt_val = 32'h22;
      tick();
      stall = 1; in_is_load = 0; in_alu_op = 5'd1; in_rd = 5'd6;
      in_rs = 5'd3; in_rs_val = 32'h99; in_rt = 5'd5; in_rt_val = 32'h77;
      for (int i = 0; i < 3; i++) begin
         in_valid = (i != 1);
         #1;
         checks++; if (hazard !== in_valid) begin errors++; $display("FAIL stall_hazard_%0d: got %b want %b", i, hazard, in_valid); end
         tick();
         checks++; if (alu_a !== 32'h11 || alu_b !== 32'h22 || alu_op !== 5'd2 || out_valid !== 1'b1 || out_rd !== 5'd3 || bubble_cnt !== 16'd2)
            begin errors++; $display("FAIL stall_hold_%0d: a=%h b=%h op=%h v=%b rd=%0d cnt=%0d want 11/22/2/1/3/2", i, alu_a, alu_b, alu_op, out_valid, out_rd, bubble_cnt); end
      end
      flush = 1; in_valid = 1;
      tick();
      checks++; if (out_valid !== 1'b0 || alu_a !== 32'd0 || alu_op !== 5'd0 || out_is_load !== 1'b0 || bubble_cnt !== 16'd2)
         begin errors++; $display("FAIL flush_stall: v=%b a=%h op=%h ld=%b cnt=%0d want 0/0/0/0/2", out_valid, alu_a, alu_op, out_is_load, bubble_cnt); end
      flush = 0; stall = 0;
      tick();
      checks++; if (out_valid !== 1'b1 || alu_op !== 5'd1 || alu_a !== 32'h99) begin errors++; $display("FAIL after_flush: v=%b op=%h a=%h want 1/1/99", out_valid, alu_op, alu_a); end
      flush = 1;
      tick();
      checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0) begin errors++; $display("FAIL flush_only: v=%b rd=%0d want 0/0", out_valid, out_rd); end
      flush = 0; stall = 1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: v=%b want 0", out_valid); end
   endtask

   task automatic test_zero_reg();
      clear_inputs();
      in_valid = 1; in_alu_op = 5'd1; in_rs = 5'd0; in_rs_val = 32'h77; in_rt = 5'd0; in_rt_val = 32'h66;
      exm_wen = 1; exm_rd = 5'd0; exm_val = 32'hFFFF_FFFF;
      mwb_wen = 1; mwb_rd = 5'd0; mwb_val = 32'hFFFF_FFFF;
      tick();
      checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL r0_forward: a=%h b=%h want 0/0", alu_a, alu_b); end
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      in_valid = 1; in_reg_write = 1;
      for (int i = 0; i < 4; i++) begin
         in_alu_op = 5'(i + 1); in_rd = 5'(i + 1); in_rs = 5'd1; in_rt = 5'd2;
         in_rs_val = 32'h10 * (i + 1); in_rt_val = 32'(i + 1);
         tick();
         checks++; if (alu_a !== 32'h10 * (i + 1) || alu_b !== 32'(i + 1) || alu_op !== 5'(i + 1) || out_rd !== 5'(i + 1))
            begin errors++; $display("FAIL b2b_%0d: a=%h b=%h op=%h rd=%0d", i, alu_a, alu_b, alu_op, out_rd); end
      end
      in_valid = 0;
      tick();
      checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_reg_write !== 1'b0) begin errors++; $display("FAIL idle_bubble: v=%b rd=%0d rw=%b want 0/0/0", out_valid, out_rd, out_reg_write); end
   endtask

   task automatic test_mid_reset();
      clear_inputs();
      in_valid = 1; in_alu_op = 5'd3; in_rs = 5'd1; in_rs_val = 32'h42; in_rd = 5'd2; in_reg_write = 1;
      tick();
      #2;
      rst_n = 0;
      #1;
      checks++; if (out_valid !== 1'b0 || alu_a !== 32'd0 || alu_op !== 5'd0 || bubble_cnt !== 16'd0)
         begin errors++; $display("FAIL async_reset: v=%b a=%h op=%h cnt=%0d want 0/0/0/0", out_valid, alu_a, alu_op, bubble_cnt); end
      tick();
      rst_n = 1;
      clear_inputs();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset: v=%b want 0", out_valid); end
   endtask

   task automatic test_saturation();
      clear_inputs();
      in_valid = 1; in_alu_op = 5'd1; in_is_load = 1; in_reg_write = 1; in_rd = 5'd4; in_rs = 5'd4;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i == 0) begin
            checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sat_hazard: got %b want 1", hazard); end
         end
         tick();
      end
      checks++; if (bubble_cnt !== 16'd15 || s_bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach: cnt=%0d narrow=%h want 15/f", bubble_cnt, s_bubble_cnt); end
      for (int i = 0; i < 5; i++) begin
         tick(); tick();
      end
      checks++; if (bubble_cnt !== 16'd20 || s_bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold: cnt=%0d narrow=%h want 20/f", bubble_cnt, s_bubble_cnt); end
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_operand_select();
      test_stall_flush();
      test_zero_reg();
      test_back_to_back();
      test_mid_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
